// File: rtl/data_collect_3ch.sv
// Three-channel word aggregator: samples clka/clkb/clkc as data in the clkd domain,
// captures each channel's word on its source-clock falling edge and merges by fixed priority.
`timescale 1ns/1ps
module data_collect_3ch #(
    parameter int DW       = 16,
    parameter int SYNC_STG = 2
) (
    input  logic          clkd,
    input  logic          rst_n,
    input  logic          clka,
    input  logic [DW-1:0] data_a,
    input  logic          data_a_vld,
    input  logic          clkb,
    input  logic [DW-1:0] data_b,
    input  logic          data_b_vld,
    input  logic          clkc,
    input  logic [DW-1:0] data_c,
    input  logic          data_c_vld,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic [1:0]    channel
);

    localparam int NCH = 3;

    logic [NCH-1:0]      src_clk_s;
    logic [NCH-1:0]      src_vld_s;
    logic [DW-1:0]       src_data_s [NCH];

    logic [SYNC_STG-1:0] clk_sync_r [NCH];
    logic [SYNC_STG-1:0] vld_dly_r  [NCH];
    logic [DW-1:0]       data_dly_r [NCH][SYNC_STG];
    logic [NCH-1:0]      clk_prev_r;
    logic [NCH-1:0]      pend_r;
    logic [DW-1:0]       hold_r     [NCH];

    logic [NCH-1:0]      cap_s;
    logic [NCH-1:0]      grant_s;
    logic [1:0]          sel_s;
    logic [DW-1:0]       win_data_s;

    assign src_clk_s     = {clkc, clkb, clka};
    assign src_vld_s     = {data_c_vld, data_b_vld, data_a_vld};
    assign src_data_s[0] = data_a;
    assign src_data_s[1] = data_b;
    assign src_data_s[2] = data_c;

    // Source-clock synchronisers with matching data/valid delay lines.
    always_ff @(posedge clkd or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                clk_sync_r[i] <= '0;
                vld_dly_r[i]  <= '0;
                for (int j = 0; j < SYNC_STG; j++) begin
                    data_dly_r[i][j] <= '0;
                end
            end
            clk_prev_r <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                clk_sync_r[i]    <= {clk_sync_r[i][SYNC_STG-2:0], src_clk_s[i]};
                vld_dly_r[i]     <= {vld_dly_r[i][SYNC_STG-2:0], src_vld_s[i]};
                data_dly_r[i][0] <= src_data_s[i];
                for (int j = 1; j < SYNC_STG; j++) begin
                    data_dly_r[i][j] <= data_dly_r[i][j-1];
                end
                clk_prev_r[i]    <= clk_sync_r[i][SYNC_STG-1];
            end
        end
    end

    // Falling-edge detect of each synchronised source clock, qualified by aligned valid.
    always_comb begin
        cap_s = '0;
        for (int i = 0; i < NCH; i++) begin
            cap_s[i] = clk_prev_r[i] & ~clk_sync_r[i][SYNC_STG-1] & vld_dly_r[i][SYNC_STG-1];
        end
    end

    // Fixed-priority arbiter A > B > C over pending words.
    always_comb begin
        grant_s    = '0;
        sel_s      = 2'd0;
        win_data_s = hold_r[0];
        if (pend_r[0]) begin
            grant_s    = 3'b001;
            sel_s      = 2'd0;
            win_data_s = hold_r[0];
        end else if (pend_r[1]) begin
            grant_s    = 3'b010;
            sel_s      = 2'd1;
            win_data_s = hold_r[1];
        end else if (pend_r[2]) begin
            grant_s    = 3'b100;
            sel_s      = 2'd2;
            win_data_s = hold_r[2];
        end else begin
            grant_s    = 3'b000;
            sel_s      = 2'd0;
            win_data_s = hold_r[0];
        end
    end

    // Hold registers and pending flags; a capture in the grant cycle keeps the flag set.
    always_ff @(posedge clkd or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold_r[i] <= '0;
            end
        end else begin
            pend_r <= cap_s | (pend_r & ~grant_s);
            for (int i = 0; i < NCH; i++) begin
                if (cap_s[i]) begin
                    hold_r[i] <= data_dly_r[i][SYNC_STG-1];
                end else begin
                    hold_r[i] <= hold_r[i];
                end
            end
        end
    end

    // Registered merged output; dout/channel keep their last values when idle.
    always_ff @(posedge clkd or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            channel  <= 2'd0;
        end else if (|grant_s) begin
            dout     <= win_data_s;
            dout_vld <= 1'b1;
            channel  <= sel_s;
        end else begin
            dout     <= dout;
            dout_vld <= 1'b0;
            channel  <= channel;
        end
    end

endmodule

// File: tb/tb_data_collect_3ch.sv
// Randomised bench for data_collect_3ch: event-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_data_collect_3ch;

    localparam int DW  = 16;
    localparam int SYN = 2;

    logic          clkd = 1'b0;
    logic          rst_n = 1'b0;
    logic          clka, clkb, clkc;
    logic [DW-1:0] data_a, data_b, data_c;
    logic          data_a_vld, data_b_vld, data_c_vld;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic [1:0]    channel;

    data_collect_3ch #(.DW(DW), .SYNC_STG(SYN)) dut (
        .clkd(clkd), .rst_n(rst_n),
        .clka(clka), .data_a(data_a), .data_a_vld(data_a_vld),
        .clkb(clkb), .data_b(data_b), .data_b_vld(data_b_vld),
        .clkc(clkc), .data_c(data_c), .data_c_vld(data_c_vld),
        .dout(dout), .dout_vld(dout_vld), .channel(channel)
    );

    always #6.25 clkd = ~clkd;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- stimulus driver (changes inputs on clkd falling edges)
    bit          manual = 1'b0;
    bit          en [3] = '{0, 0, 0};
    int          cnt [3] = '{0, 0, 0};
    int          half_min [3] = '{1, 2, 4};
    int          half_rng [3] = '{0, 0, 0};
    int          vmode [3] = '{0, 0, 0};   // 0 never valid, 1 always, 2 random
    int          dmode [3] = '{0, 0, 0};   // 0 fixed, 1 incrementing, 2 random
    logic [15:0] fixv [3] = '{16'd0, 16'd0, 16'd0};
    int          inc [3] = '{0, 0, 0};
    int          inc_max = 0;
    logic        lvl [3] = '{1'b0, 1'b0, 1'b0};
    logic        vl [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] dat [3] = '{16'd0, 16'd0, 16'd0};

    initial begin
        forever begin
            @(negedge clkd);
            if (!manual) begin
                for (int ch = 0; ch < 3; ch++) begin
                    if (!en[ch]) begin
                        lvl[ch] = 1'b0;
                        vl[ch]  = 1'b0;
                    end else if (cnt[ch] <= 1) begin
                        lvl[ch] = ~lvl[ch];
                        cnt[ch] = half_min[ch] + int'($urandom_range(0, half_rng[ch]));
                        if (lvl[ch]) begin
                            vl[ch] = (vmode[ch] == 0) ? 1'b0 :
                                     (vmode[ch] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                            if (dmode[ch] == 0) dat[ch] = fixv[ch];
                            else if (dmode[ch] == 1) begin
                                inc[ch]++;
                                dat[ch] = inc[ch][15:0];
                                if (inc[ch] > inc_max) vl[ch] = 1'b0;
                            end else dat[ch] = 16'($urandom_range(0, 65535));
                        end
                    end else cnt[ch]--;
                end
            end
            clka = lvl[0]; data_a = dat[0]; data_a_vld = vl[0];
            clkb = lvl[1]; data_b = dat[1]; data_b_vld = vl[1];
            clkc = lvl[2]; data_c = dat[2]; data_c_vld = vl[2];
        end
    end

    // ---------------- reference model: capture events scheduled SYN cycles after the
    // sampled source fall, fixed-priority emission of the newest pending word per channel
    typedef struct { int cyc; int ch; logic [15:0] d; } cap_t;
    cap_t        capq [$];
    int          mcyc = 0;
    bit          m_pend [3] = '{0, 0, 0};
    logic [15:0] m_hold [3] = '{16'd0, 16'd0, 16'd0};
    logic        m_prev [3] = '{1'b0, 1'b0, 1'b0};
    logic        exp_vld = 1'b0;
    logic [15:0] exp_dout = 16'd0;
    int          exp_ch = 0;

    initial begin
        forever begin
            @(posedge clkd or negedge rst_n);
            if (!rst_n) begin
                capq.delete();
                m_pend = '{0, 0, 0};
                m_hold = '{16'd0, 16'd0, 16'd0};
                m_prev = '{1'b0, 1'b0, 1'b0};
                exp_vld = 1'b0; exp_dout = 16'd0; exp_ch = 0;
            end else begin
                logic        rc [3];
                logic        rv [3];
                logic [15:0] rd [3];
                int          win;
                mcyc++;
                win = -1;
                for (int ch = 0; ch < 3; ch++) if (m_pend[ch] && win < 0) win = ch;
                if (win >= 0) begin
                    exp_vld = 1'b1; exp_dout = m_hold[win]; exp_ch = win; m_pend[win] = 0;
                end else exp_vld = 1'b0;
                while (capq.size() > 0 && capq[0].cyc == mcyc) begin
                    m_hold[capq[0].ch] = capq[0].d;
                    m_pend[capq[0].ch] = 1;
                    void'(capq.pop_front());
                end
                rc = '{clka, clkb, clkc};
                rv = '{data_a_vld, data_b_vld, data_c_vld};
                rd = '{data_a, data_b, data_c};
                for (int ch = 0; ch < 3; ch++) begin
                    if (m_prev[ch] && !rc[ch] && rv[ch])
                        capq.push_back('{mcyc + SYN, ch, rd[ch]});
                    m_prev[ch] = rc[ch];
                end
            end
        end
    end

    // ---------------- per-cycle compare, and a log of emitted words
    typedef struct { int cyc; int ch; int d; } ent_t;
    ent_t log_q [$];
    int   ncyc = 0;

    initial begin
        forever begin
            @(negedge clkd);
            ncyc++;
            check("dout_vld", int'(dout_vld), int'(exp_vld));
            check("dout", int'(dout), int'(exp_dout));
            check("channel", int'(channel), exp_ch);
            if (dout_vld) log_q.push_back('{ncyc, int'(channel), int'(dout)});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    function automatic int count_ch(input int ch);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].ch == ch) n++;
        return n;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clkd);
    endtask

    // ---------------- directed and random scenarios
    initial begin
        int n, k;
        logic [15:0] stale;
        #249;
        check("reset_dout", int'(dout), 0);
        check("reset_vld", int'(dout_vld), 0);
        check("reset_channel", int'(channel), 0);
        check("model_reset", int'(exp_dout), 0);
        rst_n = 1'b1;
        cycles(5);

        // B only, words 1..21 at clkd/4
        log_q.delete();
        inc[1] = 0; inc_max = 21; dmode[1] = 1; vmode[1] = 1; half_min[1] = 2; half_rng[1] = 0;
        en = '{0, 1, 0};
        cycles(110);
        check("b_count", log_q.size(), 21);
        n = (log_q.size() < 21) ? log_q.size() : 21;
        for (int i = 0; i < n; i++) begin
            check("b_word", log_q[i].d, i + 1);
            check("b_chan", log_q[i].ch, 1);
        end

        // all three constant words at 1:2, 1:4, 1:8 rates
        fixv = '{16'd1, 16'd21, 16'd3}; dmode = '{0, 0, 0}; vmode = '{1, 1, 1};
        half_min = '{1, 2, 4}; half_rng = '{0, 0, 0};
        en = '{1, 1, 1};
        cycles(20);
        log_q.delete();
        cycles(64);
        check("rate_a", (count_ch(0) >= 31 && count_ch(0) <= 33) ? 1 : 0, 1);
        check("rate_b", (count_ch(1) >= 15 && count_ch(1) <= 17) ? 1 : 0, 1);
        check("rate_c", (count_ch(2) >= 7 && count_ch(2) <= 9) ? 1 : 0, 1);
        k = 0;
        foreach (log_q[i]) if (log_q[i].d != ((log_q[i].ch == 0) ? 1 : (log_q[i].ch == 1) ? 21 : 3)) k++;
        check("rate_values", k, 0);

        // valid low while clocks toggle
        vmode = '{0, 0, 0};
        cycles(10);
        log_q.delete();
        cycles(60);
        check("novld_pulses", log_q.size(), 0);

        // simultaneous A and C capture
        manual = 1'b1;
        vl = '{1'b0, 1'b0, 1'b0};
        cycles(1);
        lvl = '{1'b0, 1'b0, 1'b0};
        cycles(6);
        log_q.delete();
        lvl = '{1'b1, 1'b0, 1'b1};
        dat = '{16'hA5A5, 16'h0000, 16'hC3C3};
        vl = '{1'b1, 1'b0, 1'b1};
        cycles(2);
        lvl = '{1'b0, 1'b0, 1'b0};
        cycles(2);
        vl = '{1'b0, 1'b0, 1'b0};
        cycles(8);
        check("ac_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("ac_first_ch", log_q[0].ch, 0);
            check("ac_first_d", log_q[0].d, 16'hA5A5);
            check("ac_second_ch", log_q[1].ch, 2);
            check("ac_second_d", log_q[1].d, 16'hC3C3);
            check("ac_gap", log_q[1].cyc - log_q[0].cyc, 1);
        end
        manual = 1'b0;

        // randomised traffic within the rate limits
        en = '{1, 1, 1}; vmode = '{2, 2, 2}; dmode = '{2, 2, 2};
        half_min = '{1, 2, 4}; half_rng = '{2, 2, 2};
        cycles(1500);

        // reset while a B word is pending
        en = '{0, 0, 0};
        cycles(10);
        en = '{0, 1, 0}; vmode[1] = 1; dmode[1] = 2; half_min[1] = 2; half_rng[1] = 0;
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clkd); #1;
            if (m_pend[1] && k == 0) k = 1;
            if (k == 1) break;
        end
        check("b_pending_seen", k, 1);
        stale = m_hold[1];
        rst_n = 1'b0;
        en[1] = 0;
        #1;
        check("rst_dout", int'(dout), 0);
        check("rst_vld", int'(dout_vld), 0);
        check("rst_channel", int'(channel), 0);
        cycles(3);
        @(negedge clkd);
        rst_n = 1'b1;
        log_q.delete();
        cycles(20);
        check("no_stale_b", log_q.size(), 0);
        if (log_q.size() > 0) $display("FAIL stale_word: got %0d after reset, pending was %0d", log_q[0].d, stale);

        // random traffic after reset
        en = '{1, 1, 1}; vmode = '{2, 2, 2}; dmode = '{2, 2, 2};
        half_min = '{1, 2, 4}; half_rng = '{3, 3, 3};
        cycles(800);
        en = '{0, 0, 0};
        cycles(10);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
